// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem
// request at a time and fills the IF/ID pipeline register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_excp
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_req;
  logic        r_kill;
  logic        r_boot;
  logic        r_err_done;
  logic [31:0] r_hold;
  logic        r_v;
  logic [31:0] r_ipc;
  logic [31:0] r_instr;
  logic        r_excp;

  logic        w_load;
  logic [31:0] w_ld_instr;
  logic        w_ld_excp;
  logic        w_nx_al;
  logic        w_pc_al;

  assign w_nx_al = (next_pc[1:0] == 2'b00);
  assign w_pc_al = (r_pc[1:0] == 2'b00);

  always_comb begin
    w_load     = 1'b0;
    w_ld_instr = imem_rdata;
    w_ld_excp  = 1'b0;
    if (!redirect && !stall) begin
      unique case (r_state)
        S_WAIT: w_load = imem_rvalid && !r_kill;
        S_HOLD: begin
          w_load     = 1'b1;
          w_ld_instr = r_hold;
        end
        S_ERR: begin
          w_load     = !r_err_done;
          w_ld_instr = 32'h0;
          w_ld_excp  = 1'b1;
        end
        default: w_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_kill     <= 1'b0;
      r_boot     <= 1'b0;
      r_err_done <= 1'b0;
      r_hold     <= 32'h0;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          if (!r_boot) begin
            r_boot <= 1'b1;
          end else begin
            r_state <= S_REQ;
            r_req   <= w_pc_al;
          end
        end
        S_REQ: begin
          if (redirect) begin
            r_pc <= next_pc;
            if (r_req && imem_gnt) begin
              r_state <= S_WAIT;
              r_kill  <= 1'b1;
              r_req   <= 1'b0;
            end else begin
              r_req <= w_nx_al;
            end
          end else if (!w_pc_al) begin
            r_state    <= S_ERR;
            r_err_done <= 1'b0;
            r_req      <= 1'b0;
          end else if (r_req && imem_gnt) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill || redirect) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
              if (redirect) begin
                r_pc  <= next_pc;
                r_req <= w_nx_al;
              end else begin
                r_req <= w_pc_al;
              end
            end else if (stall) begin
              r_hold  <= imem_rdata;
              r_state <= S_HOLD;
            end else begin
              r_pc    <= next_pc;
              r_state <= S_REQ;
              r_req   <= w_nx_al;
            end
          end else if (redirect) begin
            r_pc   <= next_pc;
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || !stall) begin
            r_pc    <= next_pc;
            r_state <= S_REQ;
            r_req   <= w_nx_al;
          end
        end
        S_ERR: begin
          if (redirect) begin
            r_pc    <= next_pc;
            r_state <= S_REQ;
            r_req   <= w_nx_al;
          end else if (!stall) begin
            r_err_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_BOOT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // redirect flushes, stall freezes, otherwise load or bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= 1'b0;
      r_ipc   <= 32'h0;
      r_instr <= 32'h0;
      r_excp  <= 1'b0;
    end else if (redirect) begin
      r_v    <= 1'b0;
      r_excp <= 1'b0;
    end else if (!stall) begin
      if (w_load) begin
        r_v     <= 1'b1;
        r_ipc   <= r_pc;
        r_instr <= w_ld_instr;
        r_excp  <= w_ld_excp;
      end else begin
        r_v    <= 1'b0;
        r_excp <= 1'b0;
      end
    end
  end

  assign pc          = r_pc;
  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign if_id_valid = r_v;
  assign if_id_pc    = r_ipc;
  assign if_id_instr = r_instr;
  assign if_id_excp  = r_excp;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small latency-configurable
// instruction memory returning addr+1000.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_excp;

  logic [31:0] tgt;
  logic        gnt_en;
  logic        ovr_en;
  logic [31:0] ovr;
  logic [31:0] m_addr = 32'h0;
  int          m_cnt = 0;
  int          lat = 1;
  int          checks = 0;
  int          fails = 0;

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .next_pc(next_pc),
    .redirect(redirect),
    .stall(stall),
    .pc(pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr),
    .if_id_excp(if_id_excp)
  );

  always #5 clk = ~clk;

  assign next_pc     = redirect ? tgt : pc + 32'd4;
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = (m_cnt == 1);
  assign imem_rdata  = ovr_en ? ovr : m_addr + 32'd1000;

  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      m_cnt  <= lat;
      m_addr <= imem_addr;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    redirect = 1'b0;
    stall    = 1'b0;
    tgt      = 32'h0;
    gnt_en   = 1'b1;
    ovr_en   = 1'b0;
    ovr      = 32'h0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_excp", {31'h0, if_id_excp}, 32'h0);
    chk("rst_ifpc", if_id_pc, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("boot_noreq", {31'h0, imem_req}, 32'h0);
    tick();
    chk("boot_req2", {31'h0, imem_req}, 32'h1);
    chk("boot_addr", imem_addr, 32'h0);
    tick();
    tick();
    chk("f0_valid", {31'h0, if_id_valid}, 32'h1);
    chk("f0_pc", if_id_pc, 32'h0);
    chk("f0_instr", if_id_instr, 32'd1000);
    chk("f0_nextpc", pc, 32'h4);
    tick();
    chk("f0_bubble", {31'h0, if_id_valid}, 32'h0);
    tick();
    chk("f1_pc", if_id_pc, 32'h4);
    chk("f1_instr", if_id_instr, 32'd1004);
    chk("f1_nextpc", pc, 32'h8);
    // stall while the response for pc 8 returns
    tick();
    stall  = 1'b1;
    ovr_en = 1'b1;
    ovr    = 32'h0000_AAAA;
    tick();
    chk("st_pc", pc, 32'h8);
    chk("st_valid", {31'h0, if_id_valid}, 32'h0);
    chk("st_ifpc", if_id_pc, 32'h4);
    chk("st_instr", if_id_instr, 32'd1004);
    chk("st_noreq", {31'h0, imem_req}, 32'h0);
    tick();
    chk("st_pc2", pc, 32'h8);
    stall  = 1'b0;
    ovr_en = 1'b0;
    tick();
    chk("hold_valid", {31'h0, if_id_valid}, 32'h1);
    chk("hold_ifpc", if_id_pc, 32'h8);
    chk("hold_instr", if_id_instr, 32'h0000_AAAA);
    chk("hold_pc", pc, 32'hC);
    // redirect while the 0x10 fetch is outstanding
    tick();
    tick();
    chk("r_pc10", pc, 32'h10);
    lat = 2;
    tick();
    redirect = 1'b1;
    tgt      = 32'h40;
    tick();
    redirect = 1'b0;
    chk("r_pc40", pc, 32'h40);
    chk("r_wait_noreq", {31'h0, imem_req}, 32'h0);
    tick();
    chk("r_valid", {31'h0, if_id_valid}, 32'h0);
    chk("r_ifpc", if_id_pc, 32'hC);
    chk("r_req", {31'h0, imem_req}, 32'h1);
    chk("r_addr", imem_addr, 32'h40);
    lat = 1;
    tick();
    tick();
    chk("r_ld_valid", {31'h0, if_id_valid}, 32'h1);
    chk("r_ld_pc", if_id_pc, 32'h40);
    chk("r_ld_instr", if_id_instr, 32'd1064);
    // redirect and stall together while in HOLD
    tick();
    stall = 1'b1;
    tick();
    chk("hs_pc", pc, 32'h44);
    chk("hs_noreq", {31'h0, imem_req}, 32'h0);
    redirect = 1'b1;
    tgt      = 32'h60;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("hs_valid", {31'h0, if_id_valid}, 32'h0);
    chk("hs_addr", imem_addr, 32'h60);
    chk("hs_req", {31'h0, imem_req}, 32'h1);
    tick();
    tick();
    chk("hs_ld_pc", if_id_pc, 32'h60);
    chk("hs_ld_instr", if_id_instr, 32'd1096);
    // abandon an ungranted request
    gnt_en   = 1'b0;
    redirect = 1'b1;
    tgt      = 32'h20;
    tick();
    redirect = 1'b0;
    chk("ab_addr20", imem_addr, 32'h20);
    chk("ab_req", {31'h0, imem_req}, 32'h1);
    tick();
    chk("ab_stable", imem_addr, 32'h20);
    redirect = 1'b1;
    tgt      = 32'h80;
    tick();
    redirect = 1'b0;
    gnt_en   = 1'b1;
    chk("ab_addr80", imem_addr, 32'h80);
    chk("ab_req80", {31'h0, imem_req}, 32'h1);
    chk("ab_valid", {31'h0, if_id_valid}, 32'h0);
    tick();
    tick();
    chk("ab_ld_pc", if_id_pc, 32'h80);
    chk("ab_ld_instr", if_id_instr, 32'd1128);
    // misaligned fetch target
    redirect = 1'b1;
    tgt      = 32'h42;
    tick();
    redirect = 1'b0;
    chk("mis_pc", pc, 32'h42);
    for (int i = 0; i < 3; i++) begin
      chk("mis_noreq", {31'h0, imem_req}, 32'h0);
      tick();
    end
    chk("mis_valid", {31'h0, if_id_valid}, 32'h1);
    chk("mis_excp", {31'h0, if_id_excp}, 32'h1);
    chk("mis_ifpc", if_id_pc, 32'h42);
    chk("mis_instr", if_id_instr, 32'h0);
    chk("mis_noreq2", {31'h0, imem_req}, 32'h0);
    tick();
    chk("mis_idle_v", {31'h0, if_id_valid}, 32'h0);
    chk("mis_idle_req", {31'h0, imem_req}, 32'h0);
    chk("mis_idle_pc", pc, 32'h42);
    redirect = 1'b1;
    tgt      = 32'h100;
    tick();
    redirect = 1'b0;
    chk("mis_res_req", {31'h0, imem_req}, 32'h1);
    chk("mis_res_addr", imem_addr, 32'h100);
    tick();
    tick();
    chk("mis_res_pc", if_id_pc, 32'h100);
    chk("mis_res_instr", if_id_instr, 32'd1256);
    chk("mis_res_excp", {31'h0, if_id_excp}, 32'h0);
    // reset asserted while a request is outstanding
    lat = 2;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rw_pc", pc, 32'h0);
    chk("rw_req", {31'h0, imem_req}, 32'h0);
    chk("rw_valid", {31'h0, if_id_valid}, 32'h0);
    #3;
    rst_n = 1'b1;
    lat   = 1;
    tick();
    chk("rw_rvalid", {31'h0, imem_rvalid}, 32'h1);
    chk("rw_boot", {31'h0, imem_req}, 32'h0);
    tick();
    chk("rw_ign", {31'h0, if_id_valid}, 32'h0);
    chk("rw_req2", {31'h0, imem_req}, 32'h1);
    chk("rw_addr", imem_addr, 32'h0);
    tick();
    tick();
    chk("rw_ld_pc", if_id_pc, 32'h0);
    chk("rw_ld_instr", if_id_instr, 32'd1000);
    chk("rw_ld_valid", {31'h0, if_id_valid}, 32'h1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage pipeline: owns the architectural PC register, issues one-outstanding requests to instruction memory, and fills the IF/ID pipeline register. It is the consumer of the next-PC selector. `pc` feeds the selector's `pc` input, and the selector's `next_pc` comes back here to be loaded. Stall and redirect come from the hazard unit and the ID-stage branch logic.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `next_pc` in 32: PC to load on the next advance or redirect. Selector output.
- `redirect` in 1: ID resolved a taken branch/J/JR/JAL this cycle. `next_pc` holds the target.
- `stall` in 1: IF/ID must hold; PC must not advance.
- `pc` out 32: current fetch PC (registered).
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, always equal to `pc`.
- `imem_gnt` in 1: request accepted this cycle (`imem_req` & `imem_gnt`).
- `imem_rvalid` in 1: read data valid. At least 1 cycle after grant; no back-pressure.
- `imem_rdata` in 32: instruction word.
- `if_id_valid` out 1: IF/ID holds a live instruction.
- `if_id_pc` out 32: PC of that instruction.
- `if_id_instr` out 32: instruction word.
- `if_id_excp` out 1: instruction is a misaligned-fetch exception marker.

## Operation
- States:
  - BOOT: one cycle after reset release, no request. Unconditionally goes to REQ.
  - REQ: `imem_req`=1. If `pc[1:0]`!=0, go to ERR instead and do not request.
    - `imem_gnt` & !`redirect` → WAIT.
    - `imem_gnt` & `redirect` → WAIT with `kill`=1 and `pc`<=`next_pc`.
    - !`imem_gnt` & `redirect`: `pc`<=`next_pc`, stay in REQ. An ungranted request may be abandoned and re-addressed.
  - WAIT: `imem_req`=0, awaiting `imem_rvalid`.
    - `redirect` without `rvalid`: `pc`<=`next_pc`, `kill`<=1.
    - `rvalid` & (`kill` | `redirect`): discard data, clear `kill`, update `pc` if `redirect`, → REQ.
    - `rvalid` & `stall`: capture data into hold buffer, → HOLD.
    - `rvalid` otherwise: load IF/ID with {`pc`, `rdata`}, `pc`<=`next_pc`, → REQ.
  - HOLD: buffered instruction waits.
    - `redirect`: drop buffer, `pc`<=`next_pc`, → REQ.
    - !`stall`: load IF/ID from buffer, `pc`<=`next_pc`, → REQ.
  - ERR: on the first cycle with !`stall`, load IF/ID with valid=1, excp=1, instr=0, pc=`pc`. Then hold with no requests until `redirect`: `pc`<=`next_pc`, → REQ.
- IF/ID register:
  - Priority: `redirect` (valid<=0, flush) > `stall` (hold all fields) > load > bubble.
  - Bubble: valid<=0 when not stalled and nothing loads.
  - pc/instr fields keep old value on bubble or flush.
- No branch delay slot: the instruction in flight at redirect is squashed.
- `pc` changes only on advance (load into IF/ID) or `redirect`. Never on `stall` alone.

## Timing
- Reset (async assert) values:
  - `pc`=`RESET_PC`
  - `imem_req`=0
  - `if_id_valid`=0, `if_id_excp`=0
  - `if_id_pc`=0, `if_id_instr`=0
  - `kill`=0, state=BOOT
- `imem_req` first rises on the 2nd rising edge after `rst_n` deasserts.
- At most one outstanding request. `imem_addr` is stable from `imem_req` rise until grant, unless `redirect` re-addresses it.
- Zero-wait memory (grant at request, rvalid the next cycle) gives a steady state of 1 instruction per 2 cycles.
- `if_id_*` update on the edge ending the `rvalid` cycle (no stall). A 1-cycle latency from `rvalid` to `if_id_valid`.
- Simultaneous `redirect` and `stall`: redirect wins.
- `rst_n` asserted while in WAIT: the state returns to BOOT. The memory response arriving after reset release is ignored; the block does not issue a new request until BOOT completes.

## Test plan
- **Reset/boot.** `RESET_PC`=0, zero-wait memory returning addr+1000. Response:
  - `imem_req` rises on the 2nd edge after reset.
  - IF/ID shows {0, 1000}, then {4, 1004}, with `next_pc`=`pc`+4.
- **Stall in WAIT.** `stall`=1 when `rvalid` returns word 0xAAAA at pc 8. Response:
  - Block enters HOLD; `pc` stays 8; IF/ID unchanged.
  - On `stall`=0, IF/ID={8, 0xAAAA} and `pc`=`next_pc`.
- **Redirect while outstanding.** Granted fetch at 0x10; `redirect` with `next_pc`=0x40 before `rvalid`. Response:
  - The 0x10 data is discarded; `if_id_valid`=0.
  - Next request address is 0x40.
- **Redirect and stall same cycle in HOLD.** Response: buffer dropped, IF/ID flushed (valid=0), next request at `next_pc`.
- **Ungranted abandon.** `imem_gnt`=0 held at addr 0x20; `redirect` with `next_pc`=0x80. Response: `imem_addr`=0x80 the next cycle; no response is consumed for 0x20.
- **Misaligned fetch.** `redirect` with `next_pc`=0x42. Response:
  - No `imem_req`.
  - IF/ID={0x42, 0} with excp=1.
  - Block idles until a `redirect` to 0x100 resumes fetching at 0x100.
